// File: rtl/uart_receiver_framed.sv
// UART receive path with elaboration-time frame format, 3-point majority sampling,
// false-start rejection and a small receive FIFO drained over ready/valid.
module uart_receiver_framed #(
  parameter int unsigned CLOCK_FREQ = 33_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 overrun,
  input  logic                 clear_errors
);

  localparam int unsigned BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned MID = BIT / 2;
  localparam int unsigned CW  = $clog2(BIT);
  localparam int unsigned BCW = 4;
  localparam int unsigned EW  = DATA_BITS + 2;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic                 sync1, rx;
  logic [2:0]           state, state_next;
  logic [CW-1:0]        cnt;
  logic                 s_a, s_b;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 pe, fe;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]          wptr, rptr;

  logic vote_point, vote, par_exp, fe_now;
  logic cnt_clr, shift_en, pe_set, fe_set, push, bit_inc, bit_clr;
  logic full, empty, pop, wr_en, drop;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx    <= sync1;
    end
  end

  assign vote_point = (cnt == CW'(MID + 1));
  assign vote       = (s_a & s_b) | (s_a & rx) | (s_b & rx);
  assign par_exp    = (PARITY == 1) ? ~(^shift) : (^shift);
  assign fe_now     = fe | ~vote;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    pe_set     = 1'b0;
    fe_set     = 1'b0;
    push       = 1'b0;
    bit_inc    = 1'b0;
    bit_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx) begin
          state_next = S_START;
          cnt_clr    = 1'b1;
        end
      end
      S_START: begin
        if (vote_point) begin
          bit_clr    = 1'b1;
          state_next = vote ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (vote_point) begin
          shift_en = 1'b1;
          if (bit_cnt == BCW'(DATA_BITS - 1)) begin
            bit_clr    = 1'b1;
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (vote_point) begin
          pe_set     = (vote != par_exp);
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (vote_point) begin
          fe_set = ~vote;
          if (bit_cnt == BCW'(STOP_BITS - 1)) begin
            // Leave at the vote rather than the bit end so an early next start still syncs.
            push       = 1'b1;
            state_next = fe_now ? S_WAIT_HIGH : S_IDLE;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bit-period counter and majority samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else begin
      if (cnt_clr)                   cnt <= '0;
      else if (state != S_IDLE)      cnt <= (cnt == CW'(BIT - 1)) ? '0 : cnt + CW'(1);
      if (cnt == CW'(MID - 1))       s_a <= rx;
      if (cnt == CW'(MID))           s_b <= rx;
    end
  end

  // Character assembly and per-frame error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      shift   <= '0;
      pe      <= 1'b0;
      fe      <= 1'b0;
    end else begin
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + BCW'(1);
      if (shift_en)     shift <= {vote, shift[DATA_BITS-1:1]};
      if (cnt_clr) begin
        pe <= 1'b0;
        fe <= 1'b0;
      end else begin
        if (pe_set) pe <= 1'b1;
        if (fe_set) fe <= 1'b1;
      end
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = data_out_valid && data_out_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // Receive FIFO with sticky overrun; a drop outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= {fe_now, pe, shift};
        wptr              <= wptr + (AW+1)'(1);
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (drop)              overrun <= 1'b1;
      else if (clear_errors) overrun <= 1'b0;
    end
  end

  assign data_out_valid = !empty;
  assign {framing_error, parity_error, data_out} = mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_uart_receiver_framed.sv
// Directed bench for uart_receiver_framed: an 8N1 instance and an 8E1 instance,
// checked against a queue-based character model plus literal expectations.
module tb_uart_receiver_framed;

  localparam int BIT   = 286;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic line0, line1;
  logic ready0, ready1;
  logic clear0, clear1;
  logic [7:0] data0, data1;
  logic pe0, pe1, fe0, fe1, valid0, valid1, ovr0, ovr1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] q0[$], q1[$];
  logic [9:0] log0[$], log1[$];
  logic       m_ovr0 = 1'b0;
  int         lat;

  always #5 clk = ~clk;

  uart_receiver_framed #(.PARITY(0)) dut (
    .clk(clk), .reset(reset), .serial_in(line0),
    .data_out(data0), .parity_error(pe0), .framing_error(fe0),
    .data_out_valid(valid0), .data_out_ready(ready0),
    .overrun(ovr0), .clear_errors(clear0)
  );

  uart_receiver_framed #(.PARITY(2)) dut_p (
    .clk(clk), .reset(reset), .serial_in(line1),
    .data_out(data1), .parity_error(pe1), .framing_error(fe1),
    .data_out_valid(valid1), .data_out_ready(ready1),
    .overrun(ovr1), .clear_errors(clear1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] logged(input int sel, input int i);
    if (sel == 0) return (i < log0.size()) ? log0[i] : 10'h3FF;
    return (i < log1.size()) ? log1[i] : 10'h3FF;
  endfunction

  task automatic drive(input int sel, input logic v, input int cycles);
    if (sel == 0) line0 = v;
    else          line1 = v;
    repeat (cycles) @(negedge clk);
  endtask

  // One frame: start, 8 data LSB-first, even parity on line 1, one stop bit.
  task automatic send_char(input int sel, input logic [7:0] d, input logic par_force,
                           input logic par_val, input logic model);
    logic       pbit;
    logic       pe_exp;
    logic [9:0] ent;
    pbit   = 1'b0;
    pe_exp = 1'b0;
    drive(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT);
    if (sel == 1) begin
      pbit   = par_force ? par_val : logic'(($countones(d) % 2) != 0);
      pe_exp = ((($countones(d) + int'(pbit)) % 2) != 0);
      drive(sel, pbit, BIT);
    end
    ent = {1'b0, pe_exp, d};
    if (model) begin
      if (sel == 0) begin
        if (q0.size() >= DEPTH) m_ovr0 = 1'b1;
        else                    q0.push_back(ent);
      end else begin
        q1.push_back(ent);
      end
    end
    drive(sel, 1'b1, BIT);
  endtask

  // Every cycle a head entry is presented it must match the oldest expected character.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid0) begin
        check("rx0_valid_has_expected", 32'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          check("rx0_head", {22'b0, fe0, pe0, data0}, {22'b0, q0[0]});
          if (ready0) begin
            log0.push_back({fe0, pe0, data0});
            void'(q0.pop_front());
          end
        end
      end
      if (valid1) begin
        check("rx1_valid_has_expected", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          check("rx1_head", {22'b0, fe1, pe1, data1}, {22'b0, q1[0]});
          if (ready1) begin
            log1.push_back({fe1, pe1, data1});
            void'(q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    line0  = 1'b1;
    line1  = 1'b1;
    ready0 = 1'b1;
    ready1 = 1'b1;
    clear0 = 1'b0;
    clear1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out",  {24'b0, data0}, 0);
    check("rst_parity",    {31'b0, pe0}, 0);
    check("rst_framing",   {31'b0, fe0}, 0);
    check("rst_valid",     {31'b0, valid0}, 0);
    check("rst_overrun",   {31'b0, ovr0}, 0);
    check("rst_valid_p",   {31'b0, valid1}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 1: 8N1 0xA5, single-cycle valid after the stop vote
    fork
      send_char(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        lat = 0;
        while (valid0 !== 1'b1 && lat < 4000) begin
          @(negedge clk);
          lat++;
        end
        check("t1_latency_near_2722", 32'(lat >= 2717 && lat <= 2727), 1);
        @(negedge clk);
        check("t1_valid_width_one", {31'b0, valid0}, 0);
      end
    join
    repeat (10) @(negedge clk);
    check("t1_count", 32'(log0.size()), 1);
    check("t1_entry", {22'b0, logged(0, 0)}, 32'h0A5);

    // 2: even parity, 0x03 with wrong then right parity bit
    send_char(1, 8'h03, 1'b1, 1'b1, 1'b1);
    send_char(1, 8'h03, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("t2_count", 32'(log1.size()), 2);
    check("t2_bad_parity",  {22'b0, logged(1, 0)}, 32'h103);
    check("t2_good_parity", {22'b0, logged(1, 1)}, 32'h003);

    // 3: 50-cycle glitch and a 1-cycle low pulse are both false starts
    drive(0, 1'b0, 50);
    drive(0, 1'b1, 12 * BIT);
    check("t3_glitch50_no_push", 32'(log0.size()), 1);
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 2 * BIT);
    check("t3_glitch1_no_push", 32'(log0.size()), 1);
    send_char(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("t3_count", 32'(log0.size()), 2);
    check("t3_entry", {22'b0, logged(0, 1)}, 32'h03C);

    // 4: 20-bit break gives exactly one framing-error entry
    drive(0, 1'b0, 5 * BIT);
    q0.push_back(10'h200);
    drive(0, 1'b0, 15 * BIT);
    drive(0, 1'b1, 2 * BIT);
    check("t4_break_count", 32'(log0.size()), 3);
    check("t4_break_entry", {22'b0, logged(0, 2)}, 32'h200);
    send_char(0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("t4_after_count", 32'(log0.size()), 4);
    check("t4_after_entry", {22'b0, logged(0, 3)}, 32'h081);

    // 5: five back-to-back characters into a 4-entry FIFO with no consumer
    ready0 = 1'b0;
    for (int i = 1; i <= 5; i++) send_char(0, 8'(i), 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("t5_overrun_set",   {31'b0, ovr0}, 1);
    check("t5_overrun_model", {31'b0, ovr0}, {31'b0, m_ovr0});
    check("t5_valid_full",    {31'b0, valid0}, 1);
    ready0 = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_drain_count", 32'(log0.size()), 8);
    for (int i = 0; i < 4; i++)
      check($sformatf("t5_drain_%0d", i), {22'b0, logged(0, 4 + i)}, 32'(i + 1));
    check("t5_empty", {31'b0, valid0}, 0);
    check("t5_overrun_sticky", {31'b0, ovr0}, 1);
    clear0 = 1'b1;
    @(negedge clk);
    clear0 = 1'b0;
    m_ovr0 = 1'b0;
    @(negedge clk);
    check("t5_overrun_cleared", {31'b0, ovr0}, 0);

    // 6: reset in the middle of data bit 4 discards the partial character
    fork
      send_char(0, 8'hF0, 1'b0, 1'b0, 1'b0);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_reset_valid", {31'b0, valid0}, 0);
      end
    join
    drive(0, 1'b1, 2 * BIT);
    check("t6_no_partial", 32'(log0.size()), 8);
    send_char(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("t6_count", 32'(log0.size()), 9);
    check("t6_entry", {22'b0, logged(0, 8)}, 32'h05A);

    check("end_rx0_all_delivered", 32'(q0.size()), 0);
    check("end_rx1_all_delivered", 32'(q1.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
